mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one 32-bit backing-memory port between the I-cache line-fill port and the CPU data port.
//  Arbitrates between the two requesters and sequences an I-cache miss into LINE_WORDS word reads.
//  Assembles those words into a full line and handles data byte/word accesses.
//  Sits between the CPU (I_CACHE fill port, data memory port) and external memory.
// PARAMETERS
//  LINE_WORDS  4   32-bit words per I-cache line (power of 2, >=2); line width = 32*LINE_WORDS
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  reset        in   1    synchronous, active-high reset
//  i_req        in   1    I-cache fill request; level, held until i_rdy
//  i_addr       in   32   fill address; low log2(LINE_WORDS)+2 bits ignored
//  i_rdata      out  32*LINE_WORDS  assembled line, word k at bits [32k+31:32k]
//  i_rdy        out  1    one-cycle pulse: fill done, i_rdata valid
//  d_req        in   1    data request; level, held until d_rdy
//  d_we         in   1    1 = store, 0 = load
//  d_size       in   1    1 = word (MEM_WORD), 0 = byte (MEM_BYTE)
//  d_addr       in   32   byte address
//  d_wdata      in   32   store data; a byte store uses bits [7:0]
//  d_rdata      out  32   load data; a byte load is sign-extended
//  d_rdy        out  1    one-cycle pulse: access done
//  mem_req      out  1    memory request; held until mem_ack
//  mem_we       out  1    write enable
//  mem_be       out  4    byte enables
//  mem_addr     out  32   word-aligned address ([1:0]=0)
//  mem_wdata    out  32   write data, byte replicated to every lane for byte stores
//  mem_rdata    in   32   read data, valid with mem_ack
//  mem_ack      in   1    one-cycle completion pulse
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE, beat=0, last_grant=I.
//   All outputs 0, including i_rdata and d_rdata; any partial line is discarded.
//   mem_req drops in the same cycle reset is sampled; a pending mem_ack is ignored.
//  FSM: IDLE, I_FILL, D_ACC.
//  IDLE arbitration, per cycle:
//   - Masking: a requester whose rdy is high this cycle is treated as not requesting.
//   - Only d_req: go to D_ACC. Only i_req: go to I_FILL.
//   - Both: go to D_ACC if last_grant==I, else I_FILL (round-robin; data wins the first tie).
//   - last_grant is updated on entry to a state. mem_req is first driven the cycle after the grant.
//  I_FILL:
//   - mem_req=1, mem_we=0, mem_be=4'hF.
//   - mem_addr = line base + 4*beat.
//   - On mem_ack: line word[beat] <= mem_rdata; beat++.
//   - On ack of beat LINE_WORDS-1: beat<=0, state<=IDLE, i_rdy=1 the next cycle.
//   - Back-to-back beats are allowed: mem_req stays high across beats and the address advances the cycle after each ack.
//  D_ACC:
//   - mem_req=1, mem_we=d_we, mem_addr={d_addr[31:2],2'b00}.
//   - Word access: mem_be=4'hF; d_addr[1:0] is ignored.
//   - Byte access: mem_be=1<<d_addr[1:0]; mem_wdata={4{d_wdata[7:0]}}.
//   - On mem_ack: state<=IDLE; d_rdy=1 the next cycle.
//   - Load d_rdata is registered at ack: word = mem_rdata; byte = sign-extended byte lane d_addr[1:0].
//   - Store d_rdata = 0.
//  Holding outputs:
//   - i_rdata and d_rdata hold until the next completion of the same port.
//   - mem_* outputs other than mem_req are 0 in IDLE.
//  mem_ack while mem_req=0 is ignored.
//  Requesters must hold address and data stable while req is high; changes are undefined.
//  A grant is never preempted. Worst-case wait for either port is one access of the other port.
// TESTING
//  Line fill: i_req, i_addr=0x104, memory returns 0xA0..0xA3 (1-cycle ack).
//   -> mem_addr 0x100,0x104,0x108,0x10C; i_rdy once; i_rdata={0xA3,0xA2,0xA1,0xA0}.
//  Byte load: d_req, d_size=0, d_addr=0x203, mem_rdata=0x80FF_FF12.
//   -> mem_addr=0x200, mem_be=4'b1000, d_rdata=0xFFFF_FF80.
//  Tie: i_req and d_req together from reset -> D_ACC first, then I_FILL.
//   With both re-asserted afterwards, grants alternate D,I,D,I.
//  Byte store: d_we=1, d_size=0, d_addr=0x11, d_wdata=0x5A.
//   -> mem_be=4'b0010, mem_wdata=0x5A5A5A5A, d_rdy pulse, d_rdata=0.
//  Reset mid-fill, after 2 acks -> next cycle mem_req=0, busy=0, i_rdy=0, i_rdata=0.
//   A new fill then starts at beat 0.
//  Stray mem_ack in IDLE and variable ack latency (0-5 wait cycles) -> no state change, correct data.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit memory port between I-cache line
// fills and CPU data accesses, with round-robin arbitration.
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [31:0]             i_addr,
  output logic [32*LINE_WORDS-1:0] i_rdata,
  output logic                    i_rdy,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic                    d_size,
  input  logic [31:0]             d_addr,
  input  logic [31:0]             d_wdata,
  output logic [31:0]             d_rdata,
  output logic                    d_rdy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy
);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_FILL = 2'd1;
  localparam logic [1:0] D_ACC  = 2'd2;

  logic [1:0]              state;
  logic [BW-1:0]           beat;
  logic                    last_d;
  logic [32*LINE_WORDS-1:0] line_q;
  logic [32*LINE_WORDS-1:0] line_nxt;
  logic                    i_want;
  logic                    d_want;
  logic                    last_beat;
  logic [7:0]              lane;
  logic [31:0]             load_val;
  logic                    unused_addr;

  assign unused_addr = ^i_addr[OFF-1:0];

  // a requester still seeing its rdy pulse has already been served
  assign i_want    = i_req & ~i_rdy;
  assign d_want    = d_req & ~d_rdy;
  assign last_beat = beat == BW'(LINE_WORDS - 1);
  assign busy      = state != IDLE;
  assign mem_req   = busy;

  assign lane     = mem_rdata[{d_addr[1:0], 3'b000} +: 8];
  assign load_val = d_size ? mem_rdata : {{24{lane[7]}}, lane};

  always_comb begin
    line_nxt = line_q;
    line_nxt[{beat, 5'b00000} +: 32] = mem_rdata;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      I_FILL: begin
        mem_be   = 4'hF;
        mem_addr = {i_addr[31:OFF], beat, 2'b00};
      end
      D_ACC: begin
        mem_we   = d_we;
        mem_addr = {d_addr[31:2], 2'b00};
        mem_be   = d_size ? 4'hF : 4'b0001 << d_addr[1:0];
        if (d_we)
          mem_wdata = d_size ? d_wdata : {4{d_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      last_d  <= 1'b0;
      line_q  <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_rdy   <= 1'b0;
      d_rdy   <= 1'b0;
    end else begin
      i_rdy <= 1'b0;
      d_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (d_want && (!i_want || !last_d)) begin
            state  <= D_ACC;
            last_d <= 1'b1;
          end else if (i_want) begin
            state  <= I_FILL;
            last_d <= 1'b0;
          end
        end
        I_FILL: begin
          if (mem_ack) begin
            line_q <= line_nxt;
            beat   <= beat + 1'b1;
            if (last_beat) begin
              beat    <= '0;
              state   <= IDLE;
              i_rdata <= line_nxt;
              i_rdy   <= 1'b1;
            end
          end
        end
        D_ACC: begin
          if (mem_ack) begin
            state   <= IDLE;
            d_rdata <= d_we ? 32'h0 : load_val;
            d_rdy   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter
// against a word-array memory reference and a round-robin order model.
module tb_mem_bus_arbiter;
  localparam int LW = 4;
  localparam int LB = LW * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [31:0]   i_addr = '0;
  logic [LB-1:0] i_rdata;
  logic          i_rdy;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic          d_size = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_rdy;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rdy(i_rdy),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_rdy(d_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy)
  );

  logic [31:0] phys [256];
  logic [31:0] refm [256];
  logic [31:0] q_addr [$];
  logic [31:0] q_wdata [$];
  logic        q_we [$];
  logic [3:0]  q_be [$];

  int            tests = 0;
  int            fails = 0;
  int            max_wait = 0;
  bit            stray_en = 1'b0;
  bit            last_d_model = 1'b0;
  logic [LB-1:0] hold_line = '0;
  logic [31:0]   hold_d = '0;

  task automatic check(input string tag, input logic [LB-1:0] obs,
                       input logic [LB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory responder: random latency, logs every accepted access
  int wcnt = 0;
  bit armed = 1'b0;
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        armed = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else if (mem_req) begin
        if (!armed) begin
          armed = 1'b1;
          wcnt = $urandom_range(0, max_wait);
        end
        if (wcnt == 0) begin
          armed = 1'b0;
          idx = int'(mem_addr[9:2]);
          check("addr_align", mem_addr[1:0], 0);
          q_addr.push_back(mem_addr);
          q_we.push_back(mem_we);
          q_be.push_back(mem_be);
          q_wdata.push_back(mem_wdata);
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) phys[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          mem_rdata = phys[idx];
          mem_ack = 1'b1;
        end else begin
          wcnt--;
        end
      end else begin
        check("idle_we", mem_we, 0);
        check("idle_be", mem_be, 0);
        check("idle_addr", mem_addr, 0);
        check("idle_wdata", mem_wdata, 0);
        check("idle_busy", busy, 0);
        if (stray_en && $urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  task automatic run(input bit di, input logic [31:0] ia, input bit dd,
                     input bit we, input bit sz, input logic [31:0] da,
                     input logic [31:0] wd, output bit d_first);
    logic [LB-1:0] exp_line;
    logic [31:0]   exp_d, exp_wd, base;
    logic [3:0]    exp_be;
    logic [7:0]    b;
    int            wi, p, n;
    bit            idone, ddone, do_d;
    base = ia & ~32'(LW * 4 - 1);
    for (int k = 0; k < LW; k++)
      exp_line[32*k +: 32] = refm[8'((base >> 2) + k)];
    wi = int'(da[9:2]);
    exp_be = sz ? 4'hF : 4'(1 << da[1:0]);
    exp_wd = 32'h0;
    exp_d = 32'h0;
    if (dd && we) begin
      exp_wd = sz ? wd : {4{wd[7:0]}};
      if (sz) refm[wi] = wd;
      else refm[wi][8*da[1:0] +: 8] = wd[7:0];
    end else if (dd) begin
      b = refm[wi][8*da[1:0] +: 8];
      exp_d = sz ? refm[wi] : {{24{b[7]}}, b};
    end
    @(negedge clk);
    i_addr = ia; i_req = di;
    d_we = we; d_size = sz; d_addr = da; d_wdata = wd; d_req = dd;
    idone = !di; ddone = !dd; d_first = 1'b0;
    for (int c = 0; c < 400 && !(idone && ddone); c++) begin
      @(negedge clk);
      if (i_rdy) begin
        check("i_rdy_once", idone, 0);
        idone = 1'b1; i_req = 1'b0;
        check("i_rdata", i_rdata, exp_line);
        hold_line = exp_line;
      end else begin
        check("i_rdata_hold", i_rdata, hold_line);
      end
      if (d_rdy) begin
        check("d_rdy_once", ddone, 0);
        if (!ddone && !(di && idone)) d_first = 1'b1;
        ddone = 1'b1; d_req = 1'b0;
        check("d_rdata", d_rdata, exp_d);
        hold_d = exp_d;
      end else begin
        check("d_rdata_hold", d_rdata, hold_d);
      end
    end
    check("done_in_time", idone && ddone, 1);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("i_rdy_pulse", i_rdy, 0);
    check("d_rdy_pulse", d_rdy, 0);
    if (di && dd) check("rr_order", d_first, !last_d_model);
    if (di && dd) last_d_model = !d_first;
    else last_d_model = dd;
    n = (di ? LW : 0) + (dd ? 1 : 0);
    check("log_len", q_addr.size(), n);
    if (q_addr.size() == n) begin
      p = 0;
      for (int s = 0; s < 2; s++) begin
        do_d = ((s == 0) == d_first);
        if (do_d && dd) begin
          check("d_bus_addr", q_addr[p], da & ~32'h3);
          check("d_bus_we", q_we[p], we);
          check("d_bus_be", q_be[p], exp_be);
          if (we) check("d_bus_wdata", q_wdata[p], exp_wd);
          p++;
        end else if (!do_d && di) begin
          for (int k = 0; k < LW; k++) begin
            check("i_bus_addr", q_addr[p], base + 32'(4 * k));
            check("i_bus_we", q_we[p], 0);
            check("i_bus_be", q_be[p], 4'hF);
            p++;
          end
        end
      end
    end
    q_addr.delete(); q_we.delete(); q_be.delete(); q_wdata.delete();
  endtask

  initial begin
    bit          df, di, dd, we, sz;
    logic [31:0] ia, da, wd;
    int          diffs;
    for (int i = 0; i < 256; i++) begin
      phys[i] = $urandom;
      refm[i] = phys[i];
    end
    refm[8'h40] = 32'hA0; refm[8'h41] = 32'hA1;
    refm[8'h42] = 32'hA2; refm[8'h43] = 32'hA3;
    refm[8'h80] = 32'h80FF_FF12;
    for (int i = 0; i < 256; i++) phys[i] = refm[i];
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_i_rdy", i_rdy, 0);
    check("rst_d_rdy", d_rdy, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    q_addr.delete(); q_we.delete(); q_be.delete(); q_wdata.delete();

    run(1, 32'h040, 1, 0, 1, 32'h300, 0, df);
    check("tie_first_d", df, 1);
    run(1, 32'h080, 1, 0, 0, 32'h301, 0, df);
    check("tie_again_d", df, 1);

    run(1, 32'h104, 0, 0, 0, 0, 0, df);
    check("fill_line", i_rdata, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    run(0, 0, 1, 0, 0, 32'h203, 0, df);
    check("byte_load", d_rdata, 32'hFFFF_FF80);

    run(0, 0, 1, 1, 0, 32'h011, 32'h5A, df);
    check("byte_store_mem", phys[4][15:8], 8'h5A);
    check("byte_store_rdata", d_rdata, 0);

    stray_en = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("stray_busy", busy, 0);
      check("stray_i_rdy", i_rdy, 0);
      check("stray_d_rdy", d_rdy, 0);
    end
    stray_en = 1'b0;

    @(negedge clk);
    i_addr = 32'h140; i_req = 1'b1;
    for (int c = 0; c < 100 && q_addr.size() < 2; c++) @(posedge clk);
    check("mid_acks", q_addr.size(), 2);
    #1 reset = 1'b1; i_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_mem_req", mem_req, 0);
    check("mid_busy", busy, 0);
    check("mid_i_rdy", i_rdy, 0);
    check("mid_i_rdata", i_rdata, 0);
    check("mid_d_rdata", d_rdata, 0);
    hold_line = '0; hold_d = '0; last_d_model = 1'b0;
    q_addr.delete(); q_we.delete(); q_be.delete(); q_wdata.delete();
    run(1, 32'h1C8, 0, 0, 0, 0, 0, df);

    max_wait = 5;
    stray_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      di = 1'($urandom_range(0, 1));
      dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
      we = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      ia = $urandom_range(0, 32'h1FF);
      da = 32'h200 + $urandom_range(0, 32'h1FF);
      wd = $urandom;
      run(di, ia, dd, we, sz, da, wd, df);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    stray_en = 1'b0;
    @(negedge clk);

    diffs = 0;
    for (int i = 0; i < 256; i++)
      if (phys[i] !== refm[i]) diffs++;
    check("mem_image", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
